vx_commit_arb_ctrl: RTL
=======================

// Module: vx_commit_arb_ctrl
// PURPOSE
//  Grant controller for one issue slot of the commit stage: selects which execution unit's
//  commit request drives the shared writeback path each cycle. Round-robin with starvation
//  override; multi-beat instructions (sop..eop) hold the grant until eop. Drives the select
//  of the data mux; the datapath itself lives in the commit stage.
// PARAMETERS
//  NUM_REQS      4   number of requesters (= NUM_EX_UNITS); legal 1..16
//  STARVE_LIMIT  8   wait cycles after which a requester is starved; legal 2..255
//  AGE_W         CLOG2(STARVE_LIMIT+1)   derived, age counter width
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-high
//  req_valid     in   NUM_REQS           per-requester commit valid
//  req_sop       in   NUM_REQS           first beat of instruction
//  req_eop       in   NUM_REQS           last beat of instruction
//  req_ready     out  NUM_REQS           per-requester accept
//  out_valid     out  1                  a grant is presented downstream
//  out_ready     in   1                  downstream accepts (writeback: tied 1)
//  grant_onehot  out  NUM_REQS           one-hot mux select
//  grant_idx     out  max(1,CLOG2(NUM_REQS))  encoded mux select
//  locked        out  1                  mid-packet lock active
//  stall_cnt     out  NUM_REQS*PERF_CTR_BITS  only with VX_COMMIT_ARB_PERF_EN
// BEHAVIOUR
//  - Zero-latency grant: combinational from req_valid and registered state; fire = out_valid & out_ready.
//  - req_ready[i] = grant_onehot[i] & out_ready; out_valid = |grant_onehot; grant_idx = encode(grant_onehot).
//  - State: UNLOCKED / LOCKED(owner); plus rr_ptr (last granted index), hold_vld/hold_idx, age[i].
//  - UNLOCKED pick: if hold_vld -> grant hold_idx; else if any valid req with age==STARVE_LIMIT ->
//    lowest such index; else first valid index searching cyclically from rr_ptr+1.
//  - Hold: out_valid & !out_ready while unlocked -> hold_vld<=1, hold_idx<=grant; cleared on fire.
//    Sources keep valid and data stable until accepted.
//  - fire with sop & !eop -> LOCKED, owner<=grant. In LOCKED: grant=owner iff req_valid[owner],
//    else out_valid=0 (bubble, lock held); all others ready=0.
//  - fire with eop (any state) -> UNLOCKED, rr_ptr<=grant. eop without sop = single beat.
//  - Beat with !sop & !eop while UNLOCKED: treated as sop (enters LOCKED).
//  - age[i]: 0 if !req_valid[i] or req_ready[i]; else saturating +1, capped at STARVE_LIMIT.
//  - Starvation does not pre-empt LOCKED or hold; applies at next arbitration point.
//  - Reset: UNLOCKED, rr_ptr=NUM_REQS-1 (req 0 wins first), hold_vld=0, ages 0. While reset is
//    high, grant_onehot=0, out_valid=0, req_ready=0, locked=0. Reset mid-packet drops the lock.
//  - NUM_REQS==1: grant_onehot = req_valid; no round-robin; lock and hold tracked normally.
// CONFIGURATION
//  VX_COMMIT_ARB_PERF_EN defined: stall_cnt[i] (+1 per cycle with req_valid[i] & !req_ready[i],
//    wraps, reset 0) is present.
//  Undefined: stall_cnt port and counters absent; all other behaviour identical.
// STRUCTURE
//  VX_gpu_pkg: commit_arb_state_t enum {CARB_UNLOCKED, CARB_LOCKED}; CARB_STARVE_DEFAULT=8.
//  Sub-module vx_commit_arb_age: one per requester, saturating age counter, starved flag.
//  Top level holds the round-robin pick, lock/hold registers and the optional perf counters.
// TESTING
//  1 All 4 valid, single-beat (sop=eop=1), out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
//  2 Req1 sends 3 beats (sop,-,eop) with req2 valid -> grant_idx=1 for 3 fires, locked=1 for
//    beats 2-3, then grant 2.
//  3 out_ready=0 for 5 cycles with req3 granted, req0 asserted later -> grant stays 3 and
//    req_ready=0 throughout; req3 fires when out_ready rises.
//  4 STARVE_LIMIT=2, req0 held off by a long packet on req2 for 4 cycles -> on eop, age0=2 and
//    req0 wins over rr order.
//  5 Reset asserted mid-packet (owner 1, locked=1) -> next cycle locked=0, out_valid=0;
//    after release, req0 wins first.
//  6 With VX_COMMIT_ARB_PERF_EN, req2 blocked 7 cycles -> stall_cnt[2]==7; build without the macro
//    compiles, port absent.

Source files
------------

// File: rtl/vx_commit_arb_ctrl_pkg.sv
// rtl/vx_commit_arb_ctrl_pkg.sv - shared types and constants for the commit-slot grant controller
// Contents:
//   commit_arb_state_t   arbitration state (unlocked / mid-packet locked)
//   CARB_STARVE_DEFAULT  default wait limit before a requester counts as starved
//   CARB_PERF_CTR_BITS   width of each optional stall counter
//   carb_idx_w()         encoded-select width, at least 1 bit
package vx_commit_arb_ctrl_pkg;

  typedef enum logic {
    CARB_UNLOCKED = 1'b0,
    CARB_LOCKED   = 1'b1
  } commit_arb_state_t;

  localparam int CARB_STARVE_DEFAULT = 8;
  localparam int CARB_PERF_CTR_BITS  = 32;

  function automatic int carb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_arb_age.sv
// rtl/vx_commit_arb_age.sv - per-requester saturating wait-age counter with starved flag
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   req_valid_i    requester is asking for the writeback path
//   req_ready_i    requester is being accepted this cycle
//   starved_o      age has reached STARVE_LIMIT
module vx_commit_arb_age
  import vx_commit_arb_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = CARB_STARVE_DEFAULT,
  parameter int AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid_i,
  input  logic req_ready_i,
  output logic starved_o
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!req_valid_i || req_ready_i) begin
      age_d = '0;
    end else if (age_q != LIMIT) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign starved_o = (age_q == LIMIT);

endmodule

// File: rtl/vx_commit_arb_ctrl.sv
// rtl/vx_commit_arb_ctrl.sv - commit-slot grant controller: round-robin, starvation override, packet lock
// Optional feature macro: VX_COMMIT_ARB_PERF_EN adds per-requester stall counters (stall_cnt).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/sop/eop   per-requester commit request and packet delimiters
//   req_ready           per-requester accept (grant & out_ready)
//   out_valid/out_ready downstream handshake
//   grant_onehot        one-hot data-mux select
//   grant_idx           encoded data-mux select
//   locked              a multi-beat packet currently owns the path
//   stall_cnt           NUM_REQS x CARB_PERF_CTR_BITS wrap counters (VX_COMMIT_ARB_PERF_EN only)
module vx_commit_arb_ctrl
  import vx_commit_arb_ctrl_pkg::*;
#(
  parameter  int NUM_REQS     = 4,
  parameter  int STARVE_LIMIT = CARB_STARVE_DEFAULT,
  localparam int AGE_W        = $clog2(STARVE_LIMIT + 1),
  localparam int IDX_W        = carb_idx_w(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_valid,
  input  logic [NUM_REQS-1:0] req_sop,
  input  logic [NUM_REQS-1:0] req_eop,
  output logic [NUM_REQS-1:0] req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                locked
`ifdef VX_COMMIT_ARB_PERF_EN
  ,
  output logic [NUM_REQS*CARB_PERF_CTR_BITS-1:0] stall_cnt
`endif
);

  commit_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    hold_idx_q, hold_idx_d;
  logic                hold_vld_q, hold_vld_d;
  logic [NUM_REQS-1:0] starved;
  logic [NUM_REQS-1:0] grant;
  logic [IDX_W-1:0]    gidx;
  logic                fire;

  // Only eop matters for packet framing: any non-eop beat taken while unlocked opens a packet.
  logic unused_sop;
  assign unused_sop = ^req_sop;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_age
    vx_commit_arb_age #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .AGE_W        (AGE_W)
    ) u_age (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid[i]),
      .req_ready_i (req_ready[i]),
      .starved_o   (starved[i])
    );
  end

  // Grant pick. Lock and hold both pin the grant; starvation only acts at a free arbitration point.
  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    found = 1'b0;
    cand  = 0;
    if (reset) begin
      grant = '0;
    end else if (state_q == CARB_LOCKED) begin
      grant[owner_q] = req_valid[owner_q];
    end else if (hold_vld_q) begin
      grant[hold_idx_q] = req_valid[hold_idx_q];
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!found && req_valid[i] && starved[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int k = 1; k <= NUM_REQS; k++) begin
        cand = (int'(rr_ptr_q) + k) % NUM_REQS;
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) gidx = gidx | IDX_W'(i);
    end
  end

  assign grant_onehot = grant;
  assign grant_idx    = gidx;
  assign out_valid    = |grant;
  assign req_ready    = grant & {NUM_REQS{out_ready}};
  assign fire         = out_valid & out_ready;
  assign locked       = (state_q == CARB_LOCKED) & ~reset;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;
    if (fire) begin
      hold_vld_d = 1'b0;
      if (req_eop[gidx]) begin
        state_d  = CARB_UNLOCKED;
        rr_ptr_d = gidx;
      end else if (state_q == CARB_UNLOCKED) begin
        state_d = CARB_LOCKED;
        owner_d = gidx;
      end
    end else if (out_valid && (state_q == CARB_UNLOCKED)) begin
      // Downstream stalled: freeze the choice so the presented beat cannot change under it.
      hold_vld_d = 1'b1;
      hold_idx_d = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CARB_UNLOCKED;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQS - 1);
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
    end
  end

`ifdef VX_COMMIT_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_perf
    logic [CARB_PERF_CTR_BITS-1:0] stall_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        stall_q <= '0;
      end else if (req_valid[i] && !req_ready[i]) begin
        stall_q <= stall_q + 1'b1;
      end
    end
    assign stall_cnt[i*CARB_PERF_CTR_BITS +: CARB_PERF_CTR_BITS] = stall_q;
  end
`endif

endmodule
